// File: rtl/square_move_collector.sv
// square_move_collector
//
// Snapshots NUM_CH move words on start, discards empty (all-zero) words and
// queues the rest into a DEPTH-entry FIFO that drains over a valid/ready
// stream towards the move generator.
//
// Optional build macro: MOVE_COLLECT_CAPTURE_FIRST_EN
//   When defined the snapshot is walked twice: first pass queues only words
//   with bit CAPTURE_BIT set (captures), second pass queues only words with
//   that bit clear (quiet moves). When undefined a single pass in channel
//   order is made and CAPTURE_BIT has no effect.
//
// Stream handshake (move_valid / move_ready / move_out):
//   move_valid is high whenever the FIFO holds at least one word and
//   move_out then carries the head word; move_out is zero while move_valid
//   is low. A word is transferred on a rising clk edge where move_valid and
//   move_ready are both high. move_valid never depends combinationally on
//   move_ready, and both move_valid and move_out change only on clk edges.

module square_move_collector #(
    parameter int NUM_CH      = 16,
    parameter int MOVE_W      = 32,
    parameter int DEPTH       = 8,
    parameter int CAPTURE_BIT = 31
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          start,
    input  logic [NUM_CH*MOVE_W-1:0]      moves_in,
    output logic                          busy,
    output logic                          done,
    output logic                          move_valid,
    input  logic                          move_ready,
    output logic [MOVE_W-1:0]             move_out,
    output logic [$clog2(NUM_CH+1)-1:0]   move_count,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level,
    output logic [2:0]                    fsm_state
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    // In the capture-first build ST_SCAN is the capture pass and
    // ST_SCAN_QUIET the quiet pass.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SCAN       = 3'd1;
    localparam logic [2:0] ST_DRAIN      = 3'd2;
    localparam logic [2:0] ST_DONE       = 3'd3;
    localparam logic [2:0] ST_SCAN_QUIET = 3'd4;

    logic [2:0]               state;
    logic [2:0]               state_next;
    logic [IDX_W-1:0]         idx;
    logic [NUM_CH*MOVE_W-1:0] snap;
    logic [CNT_W-1:0]         count;

    logic [MOVE_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LVL_W-1:0]         level;

    logic [MOVE_W-1:0]        cur_word;
    logic                     cur_nonzero;
    logic                     eligible;
    logic                     scanning;
    logic                     last_ch;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic                     advance;
    logic                     start_accept;

    // Select the snapshot word for the channel currently being examined.
    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_word = snap[k*MOVE_W +: MOVE_W];
            end
        end
    end

    assign cur_nonzero  = (cur_word != '0);
    assign last_ch      = (idx == IDX_W'(NUM_CH - 1));
    // Full looks only at the registered level, so a same-cycle pop never
    // frees a slot for a push.
    assign fifo_full    = (level == LVL_W'(DEPTH));
    assign start_accept = (state == ST_IDLE) && start;

`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
    // Capture pass takes words with the capture flag set, quiet pass the rest.
    always_comb begin
        scanning = (state == ST_SCAN) || (state == ST_SCAN_QUIET);
        eligible = cur_nonzero && (cur_word[CAPTURE_BIT] == (state == ST_SCAN));
    end
`else
    logic unused_capture_flag;
    assign unused_capture_flag = cur_word[CAPTURE_BIT];

    // Single pass: every non-empty word is taken.
    always_comb begin
        scanning = (state == ST_SCAN);
        eligible = cur_nonzero;
    end
`endif

    // A word that must be queued while the FIFO is full stalls the scan;
    // anything else moves the index on.
    assign push    = scanning && eligible && !fifo_full;
    assign advance = scanning && !(eligible && fifo_full);
    assign pop     = move_valid && move_ready;

    // Next-state decode for the scan sequencer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (advance && last_ch) begin
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
                    state_next = ST_SCAN_QUIET;
`else
                    state_next = ST_DRAIN;
`endif
                end
            end
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
            ST_SCAN_QUIET: begin
                if (advance && last_ch) begin
                    state_next = ST_DRAIN;
                end
            end
`endif
            ST_DRAIN: begin
                if (level == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; clear aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot, channel index and per-scan move counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            snap  <= '0;
            idx   <= '0;
            count <= '0;
        end else if (start_accept) begin
            snap  <= moves_in;
            idx   <= '0;
            count <= '0;
        end else begin
            if (advance) begin
                // Wrapping to zero on the last channel lets the quiet pass
                // restart at channel 0.
                idx <= last_ch ? '0 : idx + IDX_W'(1);
            end
            if (push && (count != CNT_W'(NUM_CH))) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; clear flushes the queue.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cur_word;
        end
    end

    assign move_valid = (level != '0);
    assign move_out   = move_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
    assign move_count = count;
    assign busy       = scanning || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_square_move_collector.sv
// Testbench for square_move_collector (default parameters).
// Follows MOVE_COLLECT_CAPTURE_FIRST_EN when it is defined for the build.

module tb_square_move_collector;

    localparam int NUM_CH      = 16;
    localparam int MOVE_W      = 32;
    localparam int DEPTH       = 8;
    localparam int CAPTURE_BIT = 31;
    localparam int CNT_W       = $clog2(NUM_CH + 1);
    localparam int LVL_W       = $clog2(DEPTH + 1);
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
    localparam int SCAN_CYC = 2 * NUM_CH;
    localparam int NPASS    = 2;
`else
    localparam int SCAN_CYC = NUM_CH;
    localparam int NPASS    = 1;
`endif

    logic                     clk;
    logic                     clear;
    logic                     start;
    logic [NUM_CH*MOVE_W-1:0] moves_in;
    logic                     busy;
    logic                     done;
    logic                     move_valid;
    logic                     move_ready;
    logic [MOVE_W-1:0]        move_out;
    logic [CNT_W-1:0]         move_count;
    logic [LVL_W-1:0]         fifo_level;
    logic [2:0]               fsm_state;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int t_edge    = 0;
    int done_cnt  = 0;
    int done_base = 0;
    int done_cyc  = 0;
    logic [MOVE_W-1:0] exp_q[$];

    square_move_collector #(
        .NUM_CH(NUM_CH), .MOVE_W(MOVE_W), .DEPTH(DEPTH), .CAPTURE_BIT(CAPTURE_BIT)
    ) dut (
        .clk(clk), .clear(clear), .start(start), .moves_in(moves_in),
        .busy(busy), .done(done), .move_valid(move_valid), .move_ready(move_ready),
        .move_out(move_out), .move_count(move_count), .fifo_level(fifo_level),
        .fsm_state(fsm_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model: order in which non-empty words leave the collector
    task automatic model_scan(input logic [NUM_CH*MOVE_W-1:0] mv);
        logic [MOVE_W-1:0] w;
        for (int pass = 0; pass < NPASS; pass++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w = mv[k*MOVE_W +: MOVE_W];
                if (w != '0) begin
                    if (NPASS == 1 || w[CAPTURE_BIT] == 1'(pass == 0)) begin
                        exp_q.push_back(w);
                    end
                end
            end
        end
    endtask

    // drivers
    task automatic start_scan(input logic [NUM_CH*MOVE_W-1:0] mv);
        @(posedge clk); #1;
        moves_in = mv;
        start    = 1'b1;
        model_scan(mv);
        @(posedge clk); #1;
        start     = 1'b0;
        t_edge    = cyc;
        done_base = done_cnt;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        move_ready = v;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt), 64'(done_base + 1));
    endtask

    // scoreboard: pop and compare every accepted word, log done pulses
    always @(negedge clk) begin
        logic [MOVE_W-1:0] e;
        if (move_valid && move_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_move", 64'(move_out), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("move_out", 64'(move_out), 64'(e));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc - t_edge + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH*MOVE_W-1:0] mv;
        logic [NUM_CH*MOVE_W-1:0] mv_b;
        int n;

        clear      = 1'b1;
        start      = 1'b0;
        moves_in   = '0;
        move_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_done",  64'(done), 64'(0));
        check("rst_valid", 64'(move_valid), 64'(0));
        check("rst_out",   64'(move_out), 64'(0));
        check("rst_count", 64'(move_count), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(0));
        @(posedge clk); #1;
        clear = 1'b0;

        // T1: three sparse moves, consumer always ready
        set_ready(1'b1);
        mv = '0;
        mv[1*MOVE_W +: MOVE_W] = 32'h0000_0A14;
        mv[3*MOVE_W +: MOVE_W] = 32'h0000_0B1D;
        mv[7*MOVE_W +: MOVE_W] = 32'h8000_0C2B;
        start_scan(mv);
        wait_done("t1", 80);
        check("t1_done_cycle", 64'(done_cyc), 64'(SCAN_CYC + 2));
        check("t1_move_count", 64'(move_count), 64'(3));
        check("t1_queue_left", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("t1_idle_valid", 64'(move_valid), 64'(0));

        // T2: all channels empty, busy window and done position per cycle
        mv = '0;
        start_scan(mv);
        for (int k = 1; k <= SCAN_CYC + 2; k++) begin
            @(negedge clk);
            check("t2_busy",  64'(busy), 64'(k <= SCAN_CYC + 1));
            check("t2_done",  64'(done), 64'(k == SCAN_CYC + 2));
            check("t2_valid", 64'(move_valid), 64'(0));
        end
        check("t2_done_cycle", 64'(done_cyc), 64'(SCAN_CYC + 2));
        check("t2_move_count", 64'(move_count), 64'(0));

        // T3: every channel populated with backpressure, FIFO fills and stalls
        set_ready(1'b0);
        for (int k = 0; k < NUM_CH; k++) mv[k*MOVE_W +: MOVE_W] = MOVE_W'(k + 1);
        start_scan(mv);
        n = 0;
        while (fifo_level != LVL_W'(DEPTH) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("t3_level_full", 64'(fifo_level), 64'(DEPTH));
        check("t3_stall_count", 64'(move_count), 64'(DEPTH));
        check("t3_busy", 64'(busy), 64'(1));
        check("t3_head", 64'(move_out), 64'(exp_q[0]));
        check("t3_no_done", 64'(done_cnt), 64'(done_base));
        set_ready(1'b1);
        wait_done("t3", 300);
        check("t3_move_count", 64'(move_count), 64'(NUM_CH));
        check("t3_queue_left", 64'(exp_q.size()), 64'(0));
        check("t3_level_end", 64'(fifo_level), 64'(0));

        // T4: clear during a scan with four words pending
        set_ready(1'b0);
        mv = '0;
        for (int k = 0; k < 4; k++) mv[k*MOVE_W +: MOVE_W] = MOVE_W'(32'h100 + k);
        start_scan(mv);
        repeat (4) @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("t4_level_pending", 64'(fifo_level), 64'(4));
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t4_busy",  64'(busy), 64'(0));
        check("t4_done",  64'(done), 64'(0));
        check("t4_valid", 64'(move_valid), 64'(0));
        check("t4_out",   64'(move_out), 64'(0));
        check("t4_count", 64'(move_count), 64'(0));
        check("t4_level", 64'(fifo_level), 64'(0));
        check("t4_state", 64'(fsm_state), 64'(0));
        repeat (SCAN_CYC + 5) @(negedge clk);
        check("t4_no_done", 64'(done_cnt), 64'(done_base));
        set_ready(1'b1);
        start_scan(mv);
        wait_done("t4b", 80);
        check("t4b_done_cycle", 64'(done_cyc), 64'(SCAN_CYC + 2));
        check("t4b_move_count", 64'(move_count), 64'(4));
        check("t4b_queue_left", 64'(exp_q.size()), 64'(0));

        // T5: start pulsed again mid-scan with other words must be ignored
        mv = '0;
        mv[0*MOVE_W +: MOVE_W]  = 32'h0000_0011;
        mv[13*MOVE_W +: MOVE_W] = 32'h0000_0022;
        mv_b = '0;
        mv_b[1*MOVE_W +: MOVE_W] = 32'h0000_0033;
        mv_b[5*MOVE_W +: MOVE_W] = 32'h8000_0044;
        start_scan(mv);
        repeat (3) @(posedge clk);
        #1;
        moves_in = mv_b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5", 80);
        check("t5_done_cycle", 64'(done_cyc), 64'(SCAN_CYC + 2));
        check("t5_move_count", 64'(move_count), 64'(2));
        check("t5_queue_left", 64'(exp_q.size()), 64'(0));

        // T6: mix of quiet and capture words
        mv = '0;
        mv[2*MOVE_W +: MOVE_W]  = 32'h0000_0101;
        mv[5*MOVE_W +: MOVE_W]  = 32'h8000_0202;
        mv[12*MOVE_W +: MOVE_W] = 32'h8000_0303;
        start_scan(mv);
        wait_done("t6", 80);
        check("t6_done_cycle", 64'(done_cyc), 64'(SCAN_CYC + 2));
        check("t6_move_count", 64'(move_count), 64'(3));
        check("t6_queue_left", 64'(exp_q.size()), 64'(0));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
